qrd_output_deskew: RTL and testbench

// - Sits at the output edge of the QRD-RLS systolic array and undoes the input skew the array imposes.
// - Lane k of the array result arrives k cycles after lane 0.
// - Each lane k is delayed by N-1-k cycles, so all N lanes land together as one aligned vector.
// - Aligned vectors are buffered in a small FIFO and leave on a valid/ready handshake.

---
 rtl/qrd_output_deskew_pkg.sv | 6 +
 rtl/qrd_lane_delay.sv | 41 ++++
 rtl/qrd_output_deskew.sv | 81 ++++++++
 tb/tb_qrd_output_deskew.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/qrd_output_deskew_pkg.sv
// Shared defaults for the QRD-RLS output deskew block and its lane delay.
package qrd_output_deskew_pkg;
  localparam int QRD_N           = 4;
  localparam int QRD_DATA_LENGTH = 16;
  localparam int QRD_FIFO_DEPTH  = 8;
endpackage

// File: rtl/qrd_lane_delay.sv
// D-stage delay of one lane's data and valid; the valid chain is resettable, data is not.
module qrd_lane_delay #(
  parameter int D           = 1,
  parameter int DATA_LENGTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_LENGTH-1:0] in_data,
  input  logic                   in_valid,
  output logic [DATA_LENGTH-1:0] out_data,
  output logic                   out_valid
);
  generate
    if (D == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = &{1'b0, clk, rst};
      assign out_data  = in_data;
      assign out_valid = in_valid;
    end else begin : g_pipe
      logic [D-1:0][DATA_LENGTH-1:0] dat_pipe;
      logic [D-1:0]                  vld_pipe;

      always_ff @(posedge clk) begin
        if (rst) begin
          vld_pipe <= '0;
        end else begin
          vld_pipe[0] <= in_valid;
          for (int i = 1; i < D; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
      end

      always_ff @(posedge clk) begin
        dat_pipe[0] <= in_data;
        for (int i = 1; i < D; i++) dat_pipe[i] <= dat_pipe[i-1];
      end

      assign out_data  = dat_pipe[D-1];
      assign out_valid = vld_pipe[D-1];
    end
  endgenerate
endmodule

// File: rtl/qrd_output_deskew.sv
// Undoes the systolic-array lane skew (lane k delayed N-1-k) and buffers aligned vectors in a show-ahead FIFO.
module qrd_output_deskew
  import qrd_output_deskew_pkg::*;
#(
  parameter int N           = QRD_N,
  parameter int DATA_LENGTH = QRD_DATA_LENGTH,
  parameter int FIFO_DEPTH  = QRD_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N*DATA_LENGTH-1:0] in_data,
  input  logic [N-1:0]             in_valid,
  output logic [N*DATA_LENGTH-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     overflow,
  output logic                     skew_err
);
  localparam int VW = N * DATA_LENGTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [N-1:0][DATA_LENGTH-1:0] dly_data;
  logic [N-1:0]                  dly_vld;

  genvar k;
  generate
    for (k = 0; k < N; k++) begin : g_lane
      qrd_lane_delay #(.D(N-1-k), .DATA_LENGTH(DATA_LENGTH)) u_lane (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data[k*DATA_LENGTH +: DATA_LENGTH]),
        .in_valid (in_valid[k]),
        .out_data (dly_data[k]),
        .out_valid(dly_vld[k])
      );
    end
  endgenerate

  logic align_valid, align_any;
  assign align_valid = &dly_vld;
  assign align_any   = |dly_vld;

  logic [VW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          full, empty, push, pop;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign pop   = !empty && out_ready;
  // A full FIFO still accepts when the same cycle frees a slot.
  assign push  = align_valid && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      skew_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (align_valid && !push)     overflow <= 1'b1;
      if (align_any && !align_valid) skew_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dly_data;
  end

  assign out_valid = !empty;
  assign out_data  = empty ? '0 : mem[rd_ptr];
endmodule

// File: tb/tb_qrd_output_deskew.sv
// Directed bench for qrd_output_deskew: skewed vector streams, FIFO full/overflow, skew error and reset.
module tb_qrd_output_deskew;
  localparam int N  = 4;
  localparam int DL = 16;
  localparam int FD = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DL-1:0] in_data;
  logic [N-1:0]    in_valid;
  logic [N*DL-1:0] out_data;
  logic            out_valid;
  logic            out_ready;
  logic            overflow;
  logic            skew_err;

  qrd_output_deskew #(.N(N), .DATA_LENGTH(DL), .FIFO_DEPTH(FD)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overflow (overflow),
    .skew_err (skew_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int deliv, first_cyc, last_cyc;
  int exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DL-1:0] vval(int id, int k);
    return 16'h1000 + DL'(id * 16) + DL'(k);
  endfunction

  function automatic logic [N*DL-1:0] pack(int id);
    logic [N*DL-1:0] v;
    for (int k = 0; k < N; k++) v[k*DL +: DL] = vval(id, k);
    return v;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = '0;
    in_data  = {$urandom, $urandom};
  endtask

  // Sample this cycle's pop against the scoreboard, then advance one clock.
  task automatic step();
    int id;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 64'd1, 64'd0);
      end else begin
        id = exp_q.pop_front();
        chk("out_data", out_data, pack(id));
        if (deliv == 0) first_cyc = cyc;
        last_cyc = cyc;
        deliv++;
      end
    end
    tick();
  endtask

  // Lane k carries vector (c - k) of the stream; late_lane arrives one extra cycle late.
  task automatic drive(int c, int first_id, int nvec, int late_lane);
    int j;
    for (int k = 0; k < N; k++) begin
      j = c - k - ((k == late_lane) ? 1 : 0);
      if (j >= 0 && j < nvec) begin
        in_valid[k]          = 1'b1;
        in_data[k*DL +: DL]  = vval(first_id + j, k);
      end else begin
        in_valid[k]          = 1'b0;
        in_data[k*DL +: DL]  = DL'($urandom);
      end
    end
  endtask

  task automatic stream(int first_id, int nvec, int late_lane, int extra);
    int len;
    len = nvec + N - 1 + ((late_lane >= 0) ? 1 : 0) + extra;
    for (int c = 0; c < len; c++) begin
      drive(c, first_id, nvec, late_lane);
      step();
    end
    idle();
  endtask

  // One vector with out_ready=1; out_valid must be high only N cycles after lane 0.
  task automatic timed_single(int id);
    out_ready = 1'b1;
    for (int c = 0; c <= N + 3; c++) begin
      drive(c, id, 1, -1);
      chk($sformatf("single_valid_c%0d", c), 64'(out_valid), 64'(c == N));
      if (c == N) chk("single_data", out_data, pack(id));
      tick();
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'($urandom);
    in_valid = N'($urandom);
    in_data = {$urandom, $urandom};
    tick();
    in_valid = N'($urandom);
    in_data = {$urandom, $urandom};
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_skew_err", 64'(skew_err), 64'd0);
    rst = 1'b0;
    idle();
    out_ready = 1'b1;
    tick();

    timed_single(0);
    chk("single_overflow", 64'(overflow), 64'd0);

    deliv = 0;
    for (int i = 1; i <= 20; i++) exp_q.push_back(i);
    stream(1, 20, -1, 2);
    chk("b2b_count", 64'(deliv), 64'd20);
    chk("b2b_consecutive", 64'(last_cyc - first_cyc), 64'd19);
    chk("b2b_overflow", 64'(overflow), 64'd0);
    chk("b2b_q_empty", 64'(exp_q.size()), 64'd0);

    out_ready = 1'b0;
    for (int i = 21; i <= 28; i++) exp_q.push_back(i);
    stream(21, 9, -1, 0);
    chk("full_count", 64'(dut.count), 64'd8);
    chk("full_overflow", 64'(overflow), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < FD; i++) step();
    chk("drain_empty", 64'(out_valid), 64'd0);
    chk("drain_q_empty", 64'(exp_q.size()), 64'd0);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b0;
    for (int i = 31; i <= 39; i++) exp_q.push_back(i);
    stream(31, 8, -1, 0);
    chk("fill_count", 64'(dut.count), 64'd8);
    chk("fill_overflow", 64'(overflow), 64'd0);
    for (int c = 0; c < N; c++) begin
      drive(c, 39, 1, -1);
      out_ready = (c == N - 1);
      step();
    end
    idle();
    out_ready = 1'b0;
    chk("rw_full_count", 64'(dut.count), 64'd8);
    chk("rw_full_overflow", 64'(overflow), 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < FD; i++) step();
    chk("rw_drain_q_empty", 64'(exp_q.size()), 64'd0);
    chk("rw_drain_valid", 64'(out_valid), 64'd0);

    stream(50, 1, 2, 1);
    chk("skew_err_set", 64'(skew_err), 64'd1);
    chk("skew_nothing_written", 64'(dut.count), 64'd0);
    chk("skew_out_valid", 64'(out_valid), 64'd0);
    chk("skew_overflow", 64'(overflow), 64'd0);

    drive(0, 60, 1, -1);
    step();
    drive(1, 60, 1, -1);
    step();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_skew_err", 64'(skew_err), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_data", out_data, 64'd0);
    timed_single(61);
    chk("post_rst_skew_err", 64'(skew_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
